// File: rtl/axi_lite_settings_bridge_if.sv
// AXI4-Lite slave-side bus bundle for the settings bridge.
// Signals carry the s_axi_ role through the instance name (s_axi.awaddr etc.).
interface axi_lite_settings_bridge_if #(
    parameter int C_DATAWIDTH = 32,
    parameter int C_ADDRWIDTH = 32
);
    logic [C_ADDRWIDTH-1:0]   awaddr;
    logic                     awvalid;
    logic                     awready;
    logic [C_DATAWIDTH-1:0]   wdata;
    logic [C_DATAWIDTH/8-1:0] wstrb;
    logic                     wvalid;
    logic                     wready;
    logic [1:0]               bresp;
    logic                     bvalid;
    logic                     bready;
    logic [C_ADDRWIDTH-1:0]   araddr;
    logic                     arvalid;
    logic                     arready;
    logic [C_DATAWIDTH-1:0]   rdata;
    logic [1:0]               rresp;
    logic                     rvalid;
    logic                     rready;

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_settings_bridge.sv
// AXI4-Lite slave turning host writes into set_stb pulses and host reads into
// get_stb pulses; independent write and read FSMs, addresses pass through.
module axi_lite_settings_bridge #(
    parameter int C_DATAWIDTH = 32,
    parameter int C_ADDRWIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    axi_lite_settings_bridge_if.slave s_axi,
    output logic [C_DATAWIDTH-1:0] set_data,
    output logic [C_ADDRWIDTH-1:0] set_addr,
    output logic                   set_stb,
    output logic [C_ADDRWIDTH-1:0] get_addr,
    output logic                   get_stb,
    input  logic [C_DATAWIDTH-1:0] get_data
);
    typedef enum logic [1:0] {W_IDLE = 2'd0, W_STB = 2'd1, W_RESP = 2'd2} w_state_e;
    typedef enum logic [1:0] {R_IDLE = 2'd0, R_GET = 2'd1, R_RESP = 2'd2} r_state_e;

    w_state_e                 w_state_q;
    r_state_e                 r_state_q;
    logic                     aw_latched_q, w_latched_q;
    logic [C_ADDRWIDTH-1:0]   awaddr_q;
    logic [C_DATAWIDTH-1:0]   wdata_q;
    logic [C_DATAWIDTH/8-1:0] wstrb_q;
    logic                     awready_q, wready_q, bvalid_q, set_stb_q;
    logic [1:0]               bresp_q, rresp_q;
    logic [C_ADDRWIDTH-1:0]   set_addr_q, get_addr_q;
    logic [C_DATAWIDTH-1:0]   set_data_q, rdata_q;
    logic                     arready_q, rvalid_q, get_stb_q;

    // A beat completing this cycle counts as latched, so AW/W in the same cycle start W_STB at once.
    logic                     aw_hs_s, w_hs_s, aw_done_s, w_done_s, full_s;
    logic [C_ADDRWIDTH-1:0]   awaddr_s;
    logic [C_DATAWIDTH-1:0]   wdata_s;
    logic [C_DATAWIDTH/8-1:0] wstrb_s;

    assign aw_hs_s   = s_axi.awvalid & awready_q;
    assign w_hs_s    = s_axi.wvalid & wready_q;
    assign aw_done_s = aw_latched_q | aw_hs_s;
    assign w_done_s  = w_latched_q | w_hs_s;
    assign awaddr_s  = aw_latched_q ? awaddr_q : s_axi.awaddr;
    assign wdata_s   = w_latched_q ? wdata_q : s_axi.wdata;
    assign wstrb_s   = w_latched_q ? wstrb_q : s_axi.wstrb;
    assign full_s    = &wstrb_s;

    // Write FSM: collect AW and W, issue one set_stb (full-strobe only), then respond on B.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q    <= W_IDLE;
            aw_latched_q <= 1'b0;
            w_latched_q  <= 1'b0;
            awaddr_q     <= {C_ADDRWIDTH{1'b0}};
            wdata_q      <= {C_DATAWIDTH{1'b0}};
            wstrb_q      <= {(C_DATAWIDTH/8){1'b0}};
            awready_q    <= 1'b0;
            wready_q     <= 1'b0;
            bvalid_q     <= 1'b0;
            bresp_q      <= 2'b00;
            set_stb_q    <= 1'b0;
            set_addr_q   <= {C_ADDRWIDTH{1'b0}};
            set_data_q   <= {C_DATAWIDTH{1'b0}};
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    if (aw_hs_s) begin
                        aw_latched_q <= 1'b1;
                        awaddr_q     <= s_axi.awaddr;
                    end
                    if (w_hs_s) begin
                        w_latched_q <= 1'b1;
                        wdata_q     <= s_axi.wdata;
                        wstrb_q     <= s_axi.wstrb;
                    end
                    if (aw_done_s && w_done_s) begin
                        awready_q <= 1'b0;
                        wready_q  <= 1'b0;
                        set_stb_q <= full_s;
                        bresp_q   <= full_s ? 2'b00 : 2'b10;
                        if (full_s) begin
                            set_addr_q <= awaddr_s;
                            set_data_q <= wdata_s;
                        end
                        w_state_q <= W_STB;
                    end else begin
                        awready_q <= ~aw_done_s;
                        wready_q  <= ~w_done_s;
                    end
                end
                W_STB: begin
                    set_stb_q <= 1'b0;
                    bvalid_q  <= 1'b1;
                    w_state_q <= W_RESP;
                end
                W_RESP: begin
                    if (s_axi.bready) begin
                        bvalid_q     <= 1'b0;
                        bresp_q      <= 2'b00;
                        aw_latched_q <= 1'b0;
                        w_latched_q  <= 1'b0;
                        awready_q    <= 1'b1;
                        wready_q     <= 1'b1;
                        w_state_q    <= W_IDLE;
                    end
                end
                default: begin
                    set_stb_q <= 1'b0;
                    bvalid_q  <= 1'b0;
                    w_state_q <= W_IDLE;
                end
            endcase
        end
    end

    // Read FSM: one get_stb cycle, capture get_data at its end, hold R until rready.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q  <= R_IDLE;
            arready_q  <= 1'b0;
            get_stb_q  <= 1'b0;
            get_addr_q <= {C_ADDRWIDTH{1'b0}};
            rvalid_q   <= 1'b0;
            rdata_q    <= {C_DATAWIDTH{1'b0}};
            rresp_q    <= 2'b00;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    if (s_axi.arvalid && arready_q) begin
                        arready_q  <= 1'b0;
                        get_addr_q <= s_axi.araddr;
                        get_stb_q  <= 1'b1;
                        r_state_q  <= R_GET;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                R_GET: begin
                    get_stb_q <= 1'b0;
                    rdata_q   <= get_data;
                    rresp_q   <= 2'b00;
                    rvalid_q  <= 1'b1;
                    r_state_q <= R_RESP;
                end
                R_RESP: begin
                    if (s_axi.rready) begin
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                        r_state_q <= R_IDLE;
                    end
                end
                default: begin
                    get_stb_q <= 1'b0;
                    rvalid_q  <= 1'b0;
                    r_state_q <= R_IDLE;
                end
            endcase
        end
    end

    // Readies are masked by rst so the host never sees a handshake during reset.
    assign s_axi.awready = awready_q & ~rst;
    assign s_axi.wready  = wready_q & ~rst;
    assign s_axi.arready = arready_q & ~rst;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = bresp_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rresp   = rresp_q;
    assign s_axi.rdata   = rdata_q;
    assign set_stb       = set_stb_q;
    assign set_addr      = set_addr_q;
    assign set_data      = set_data_q;
    assign get_stb       = get_stb_q;
    assign get_addr      = get_addr_q;
endmodule

// File: doc/axi_lite_settings_bridge.md
Name: axi_lite_settings_bridge

Overview:
- AXI4-Lite slave that converts host register accesses into the settings bus: writes become single-cycle set_stb/set_addr/set_data strobes, reads become get_stb/get_addr with get_data sampled back.
- Sits directly upstream of the global settings register page and the per-stream settings pages, between the PS general-purpose AXI port and those consumers.
- No address decoding is done here; addresses pass through unchanged.

Parameters:
C_DATAWIDTH, 32, AXI data width and settings data width.
C_ADDRWIDTH, 32, AXI address width and settings address width.

Ports:
clk  in  1  system clock; all logic on its rising edge
rst  in  1  reset, synchronous, active-high
s_axi_awaddr  in  C_ADDRWIDTH  write address
s_axi_awvalid  in  1  write address valid
s_axi_awready  out  1  write address ready
s_axi_wdata  in  C_DATAWIDTH  write data
s_axi_wstrb  in  C_DATAWIDTH/8  write byte strobes
s_axi_wvalid  in  1  write data valid
s_axi_wready  out  1  write data ready
s_axi_bresp  out  2  write response
s_axi_bvalid  out  1  write response valid
s_axi_bready  in  1  write response ready
s_axi_araddr  in  C_ADDRWIDTH  read address
s_axi_arvalid  in  1  read address valid
s_axi_arready  out  1  read address ready
s_axi_rdata  out  C_DATAWIDTH  read data
s_axi_rresp  out  2  read response
s_axi_rvalid  out  1  read data valid
s_axi_rready  in  1  read data ready
set_data  out  C_DATAWIDTH  settings write data
set_addr  out  C_ADDRWIDTH  settings write address
set_stb  out  1  settings write strobe, one cycle per write
get_addr  out  C_ADDRWIDTH  settings read address
get_stb  out  1  settings read strobe, one cycle per read
get_data  in  C_DATAWIDTH  settings read data; combinational from get_addr/get_stb

Behaviour:
- Reset: all FSMs go to IDLE, latches clear. s_axi_awready, wready, arready, bvalid, rvalid, set_stb and get_stb are 0. bresp, rresp, rdata, set_addr, set_data and get_addr are 0. Readies are forced to 0 while rst is high.
- Write FSM states: W_IDLE, W_STB, W_RESP.
  - W_IDLE: awready=1 until an address is latched; wready=1 until data is latched.
  - AW and W may arrive in either order or in the same cycle. Each is latched on its own handshake.
  - When both are latched, go to W_STB.
- W_STB, one cycle:
  - If wstrb is all ones: set_stb=1, with set_addr/set_data driven from the latches.
  - Otherwise: set_stb=0 and bresp is set to 2'b10 (SLVERR); partial writes are never forwarded.
  - Then go to W_RESP.
- W_RESP: bvalid=1 and bresp is held (2'b00 OKAY unless SLVERR) until bready. On the handshake, clear the latches and return to W_IDLE. No new AW/W is accepted before then.
- Write latency: the set_stb cycle immediately follows the edge that completes the second of AW/W. bvalid asserts the following cycle, so it can be seen 2 cycles after that edge at the earliest.
- Read FSM states: R_IDLE, R_GET, R_RESP.
  - R_IDLE: arready=1. On the handshake, latch araddr and go to R_GET.
  - R_GET, one cycle: get_stb=1 and get_addr=latched address. rdata is captured from get_data at the end of this cycle and rresp=2'b00. Go to R_RESP.
  - R_RESP: rvalid=1 with rdata held stable until rready. Then return to R_IDLE.
- Read latency: rvalid asserts 2 cycles after the AR handshake edge.
- Read and write paths are fully independent. A set_stb and a get_stb in the same cycle are legal.
- set_addr/set_data hold their last value outside set_stb. get_addr holds its last value outside get_stb.
- Back-pressure: bready or rready held low keeps bvalid/rvalid asserted and the payload stable indefinitely.
- Reset asserted mid-transaction: the transaction is abandoned. No set_stb or get_stb is issued after the reset edge, and outputs return to their reset values on the next edge.

Test Plan:
- AW and W in the same cycle (addr 0x4, data 0x1F, wstrb 0xF) -> set_stb one cycle later with set_addr=0x4, set_data=0x1F; bvalid the next cycle with bresp=00.
- W three cycles before AW (addr 0x8, data 0x3) -> exactly one set_stb, issued only after AW; set_data=0x3; wready stays low after the W latch until the B handshake.
- Read addr 0x0 with get_data model returning 0xACE0BA53 when addr[11:2]==0 -> get_stb pulses once with get_addr=0x0; rvalid 2 cycles after AR with rdata=0xACE0BA53, rresp=00.
- Partial write, wstrb=0x3 -> no set_stb; bresp=10.
- Write to 0xC while a read of 0x1C is in flight, rready held low 5 cycles -> set_stb and get_stb unaffected by each other; rvalid stays high with rdata stable for 5 cycles; one R handshake.
- rst pulsed in W_RESP and in R_GET -> bvalid/rvalid drop, no further strobes, and the next write completes normally.
